// File: rtl/ppu_write_scheduler.sv
// Sprite-register write scheduler: queues CPU writes and replays them in vblank.
// Optional vblank interrupt is compiled in with PPU_VBLANK_IRQ_EN.
module ppu_write_scheduler #(
    parameter int DEPTH        = 16,
    parameter int VBLANK_START = 480,
    parameter int VLINES       = 525
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   chipselect,
    input  logic                   write,
    input  logic [2:0]             address,
    input  logic [31:0]            writedata,
    input  logic [9:0]             vcount,
    output logic [31:0]            sprite_wdata,
    output logic                   sprite_wvalid,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   q_overflow,
    output logic                   in_vblank,
    output logic                   irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
    localparam logic [10:0] VB11 = VBLANK_START[10:0];
    localparam logic [10:0] VL11 = VLINES[10:0];
    localparam logic [9:0]  VB10 = VBLANK_START[9:0];

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [9:0]  vcount_q, vcount_d, vprev_q, vprev_d;
    logic        vblank_q, vblank_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wvalid_q, wvalid_d;
    logic        ovf_q, ovf_d;
    logic        bypass_q, bypass_d;
    logic        irq_q, irq_d;
    logic [31:0] mem_q [DEPTH];

    logic        push_req, ctrl_wr, byp_fire;
    logic        start, pop, push, drop;
    logic [AW:0] count, count_d;

    always_comb begin
        push_req = chipselect && write && (address == 3'd0);
        ctrl_wr  = chipselect && write && (address == 3'd1);
        byp_fire = push_req && bypass_q;
        count    = wr_q - rd_q;
        start    = (vcount_q == VB10) && (vprev_q != VB10);
        // a bypass strobe owns the output bus, so the drain waits a cycle
        pop      = (state_q == DRAIN) && vblank_q &&
                   (count != '0) && !byp_fire;
        push     = push_req && !bypass_q && ((count != FULL) || pop);
        drop     = push_req && !bypass_q && (count == FULL) && !pop;

        wr_d     = push ? wr_q + PONE : wr_q;
        rd_d     = pop ? rd_q + PONE : rd_q;
        count_d  = wr_d - rd_d;

        vcount_d = vcount;
        vprev_d  = vcount_q;
        vblank_d = ({1'b0, vcount} >= VB11) || ({1'b0, vcount} >= VL11);

        state_d = state_q;
        unique case (state_q)
            ACTIVE: if (start) state_d = DRAIN;
            DRAIN: begin
                if (!vblank_q) state_d = ACTIVE;
                else if (count_d == '0) state_d = HOLD;
            end
            HOLD: begin
                if (!vblank_q) state_d = ACTIVE;
                else if (push) state_d = DRAIN;
            end
            default: state_d = ACTIVE;
        endcase

        wvalid_d = byp_fire || pop;
        wdata_d  = wdata_q;
        if (byp_fire) wdata_d = writedata;
        else if (pop) wdata_d = mem_q[rd_q[AW-1:0]];

        ovf_d = ovf_q;
        if (drop) ovf_d = 1'b1;
        else if (ctrl_wr && writedata[0]) ovf_d = 1'b0;

        bypass_d = ctrl_wr ? writedata[1] : bypass_q;

`ifdef PPU_VBLANK_IRQ_EN
        irq_d = irq_q;
        if ((state_q == ACTIVE) && start) irq_d = 1'b1;
        else if (ctrl_wr && writedata[2]) irq_d = 1'b0;
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ACTIVE;
            wr_q     <= '0;
            rd_q     <= '0;
            vcount_q <= '0;
            vprev_q  <= '0;
            vblank_q <= 1'b0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            bypass_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            vcount_q <= vcount_d;
            vprev_q  <= vprev_d;
            vblank_q <= vblank_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            ovf_q    <= ovf_d;
            bypass_q <= bypass_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= writedata;
    end

    assign sprite_wdata  = wdata_q;
    assign sprite_wvalid = wvalid_q;
    assign q_count       = count;
    assign q_overflow    = ovf_q;
    assign in_vblank     = vblank_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_ppu_write_scheduler.sv
// Bench for ppu_write_scheduler: directed frame scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_ppu_write_scheduler;
    localparam int DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   chipselect = 1'b0;
    logic                   write = 1'b0;
    logic [2:0]             address = '0;
    logic [31:0]            writedata = '0;
    logic [9:0]             vcount = '0;
    logic [31:0]            sprite_wdata;
    logic                   sprite_wvalid;
    logic [$clog2(DEPTH):0] q_count;
    logic                   q_overflow;
    logic                   in_vblank;
    logic                   irq;

    always #5 clk = ~clk;

    ppu_write_scheduler #(
        .DEPTH(DEPTH),
        .VBLANK_START(480),
        .VLINES(525)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chipselect(chipselect),
        .write(write),
        .address(address),
        .writedata(writedata),
        .vcount(vcount),
        .sprite_wdata(sprite_wdata),
        .sprite_wvalid(sprite_wvalid),
        .q_count(q_count),
        .q_overflow(q_overflow),
        .in_vblank(in_vblank),
        .irq(irq)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: a plain FIFO plus a "blanking window" flag that opens
    // the cycle after a fresh VBLANK_START line and closes when blank ends.
    logic [31:0] mq[$];
    logic [9:0]  m_vq = '0, m_vprev = '0;
    bit          m_win, m_ovf, m_byp, m_irq, m_wvalid;
    logic [31:0] m_wdata = '0;
    bit          preq, ctrl, fire, pop, blank, start;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_vq = '0; m_vprev = '0; m_win = 0; m_ovf = 0;
            m_byp = 0; m_irq = 0; m_wvalid = 0; m_wdata = '0;
        end else begin
            preq  = chipselect && write && address == 3'd0;
            ctrl  = chipselect && write && address == 3'd1;
            blank = m_vq >= 10'd480;
            start = m_vq == 10'd480 && m_vprev != 10'd480;
            fire  = preq && m_byp;
            pop   = m_win && blank && mq.size() > 0 && !fire;
            m_wvalid = fire || pop;
            if (fire) m_wdata = writedata;
            else if (pop) m_wdata = mq.pop_front();
            if (preq && !m_byp) begin
                if (mq.size() < DEPTH) mq.push_back(writedata);
                else m_ovf = 1;
            end
            if (ctrl && writedata[0]) m_ovf = 0;
`ifdef PPU_VBLANK_IRQ_EN
            if (start && !m_win) m_irq = 1;
            else if (ctrl && writedata[2]) m_irq = 0;
`endif
            m_win = blank && (m_win || start);
            if (ctrl) m_byp = writedata[1];
            m_vprev = m_vq;
            m_vq = vcount;
        end
        #1;
        chk("m_wvalid", sprite_wvalid, m_wvalid);
        chk("m_wdata", sprite_wdata, m_wdata);
        chk("m_count", q_count, mq.size());
        chk("m_ovf", q_overflow, m_ovf);
        chk("m_vblank", in_vblank, m_vq >= 10'd480);
        chk("m_irq", irq, m_irq);
    end

    logic [31:0] got[$];
    int          first_k, irq_k;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1; write = 1; address = a; writedata = d;
        step(1);
        chipselect = 0; write = 0;
    endtask

    task automatic clr();
        got.delete(); first_k = -1; irq_k = -1;
    endtask

    task automatic collect(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (sprite_wvalid) begin
                if (got.size() == 0) first_k = k;
                got.push_back(sprite_wdata);
            end
            if (irq && irq_k < 0) irq_k = k;
        end
    endtask

    logic [9:0] vals [10] = '{10'd0, 10'd100, 10'd200, 10'd479, 10'd480,
                              10'd481, 10'd490, 10'd524, 10'd600, 10'd1023};

    initial begin
        int hold, r;
        step(2);
        reset = 0;
        chk("rst_wvalid", sprite_wvalid, 0);
        chk("rst_wdata", sprite_wdata, 0);
        chk("rst_count", q_count, 0);
        chk("rst_ovf", q_overflow, 0);
        chk("rst_vblank", in_vblank, 0);
        chk("rst_irq", irq, 0);

        vcount = 100;
        bus(0, 32'hA1); bus(0, 32'hA2); bus(0, 32'hA3);
        step(1);
        chk("t1_count", q_count, 3);
        chk("t1_nostrobe", sprite_wvalid, 0);
        vcount = 479; step(2);
        clr(); vcount = 480; collect(8);
        chk("t1_nstrb", got.size(), 3);
        chk("t1_first", first_k, 2);
        if (got.size() == 3) begin
            chk("t1_d0", got[0], 32'hA1);
            chk("t1_d1", got[1], 32'hA2);
            chk("t1_d2", got[2], 32'hA3);
        end
        chk("t1_empty", q_count, 0);
`ifdef PPU_VBLANK_IRQ_EN
        chk("t1_irq_k", irq_k, 1);
        bus(1, 32'h4);
        chk("t1_irq_clr", irq, 0);
`else
        chk("t1_irq_k", irq_k, -1);
`endif
        vcount = 100; step(2);

        for (int i = 0; i <= DEPTH; i++) bus(0, 32'h100 + i);
        chk("t2_count", q_count, DEPTH);
        chk("t2_ovf", q_overflow, 1);
        bus(1, 32'h1);
        chk("t2_ovf_clr", q_overflow, 0);
        vcount = 479; step(1);
        clr(); vcount = 480; collect(24);
        chk("t2_nstrb", got.size(), DEPTH);
        if (got.size() == DEPTH) begin
            chk("t2_head", got[0], 32'h100);
            chk("t2_tail", got[DEPTH-1], 32'h10F);
        end
        vcount = 100; step(2);

        for (int i = 0; i < DEPTH; i++) bus(0, 32'h200 + i);
        vcount = 479; step(1);
        clr(); vcount = 480; collect(7);
        vcount = 0; collect(5);
        chk("t3_nstrb", got.size(), 6);
        chk("t3_left", q_count, 10);
        if (got.size() == 6) chk("t3_last", got[5], 32'h205);
        vcount = 479; step(1);
        clr(); vcount = 480; collect(16);
        chk("t3_nstrb2", got.size(), 10);
        if (got.size() == 10) begin
            chk("t3_head2", got[0], 32'h206);
            chk("t3_tail2", got[9], 32'h20F);
        end
        vcount = 200; step(2);

        bus(1, 32'h2);
        bus(0, 32'h55);
        chk("t4_wdata", sprite_wdata, 32'h55);
        chk("t4_wvalid", sprite_wvalid, 1);
        chk("t4_count", q_count, 0);
        bus(1, 32'h0);
        step(1);

        for (int i = 0; i < 5; i++) bus(0, 32'h300 + i);
        vcount = 479; step(1);
        vcount = 480; step(3);
        reset = 1; step(1);
        reset = 0; vcount = 100;
        chk("t5_count", q_count, 0);
        chk("t5_wvalid", sprite_wvalid, 0);
        step(2);
        vcount = 479; step(1);
        clr(); vcount = 480; collect(10);
        chk("t5_nstrb", got.size(), 0);
        vcount = 100; step(2);

        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                vcount = vals[$urandom_range(0, 9)];
                hold = $urandom_range(1, 12);
            end
            hold--;
            reset = ($urandom_range(0, 599) == 0);
            r = $urandom_range(0, 99);
            chipselect = r < 60;
            write = $urandom_range(0, 9) != 0;
            if (r < 45) address = 3'd0;
            else if (r < 52) address = 3'd1;
            else address = 3'($urandom_range(2, 7));
            writedata = $urandom;
            if (address == 3'd1) writedata[1] = ($urandom_range(0, 3) == 0);
            step(1);
        end
        reset = 0; chipselect = 0; write = 0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
